seg_scan_ctrl: RTL

//  Time-multiplexed scan controller for a bank of NDIG common-anode 7-segment digits.

---
 rtl/seg_scan_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for NDIG common-anode
// 7-segment digits. A double-buffered hex value (shadow -> active) is committed
// only at a frame wrap or when scanning starts, so a frame never mixes old and
// new data. Each digit slot is CLK_DIV cycles: a drive phase followed by
// BLANK_CYC cycles with every anode off to suppress ghosting.
// Optional feature: define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan_ctrl #(
   parameter int NDIG      = 4,
   parameter int CLK_DIV   = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [4*NDIG-1:0] value,
   input  logic [NDIG-1:0]   dp_in,
   input  logic              load,
   output logic              load_ack,
   output logic [6:0]        seg_n,
   output logic              dp_n,
   output logic [NDIG-1:0]   an_n,
   output logic              frame_tick
);

   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      BLANK = 2'd2
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;
   logic [4*NDIG-1:0]   shadow_val;
   logic [NDIG-1:0]     shadow_dp;
   logic [4*NDIG-1:0]   active_val;
   logic [NDIG-1:0]     active_dp;
   logic                pending;

   logic                slot_end;
   logic                wrap;
   logic                commit;
   logic [6:0]          nxt_seg;
   logic                nxt_dp;
   logic [NDIG-1:0]     nxt_an;

   // Hex nibble to active-low {g,f,e,d,c,b,a}.
   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
         4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Slot/frame boundaries and the commit decision for the coming edge.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      slot_end = 1'b0;
      if (state == DRIVE && BLANK_CYC == 0 && cnt == DRIVE_LAST) slot_end = 1'b1;
      if (state == BLANK && cnt == SLOT_LAST)                    slot_end = 1'b1;
      wrap   = slot_end && (idx == IDX_LAST);
      commit = enable && pending && (state == IDLE || wrap);
   end

   // Next value of the registered pin outputs, derived from the current state.
   always_comb begin
      logic lz_dark;
      nxt_seg = 7'h7F;
      nxt_dp  = 1'b1;
      nxt_an  = '1;
`ifdef SEG_SCAN_LZB_EN
      // Dark if this and every higher nibble is zero, except for digit 0.
      lz_dark = (idx != '0);
      for (int k = 0; k < NDIG; k++)
         if (k >= int'(idx) && active_val[4*k +: 4] != 4'h0) lz_dark = 1'b0;
`else
      lz_dark = 1'b0;
`endif
      if (enable && state == DRIVE) begin
         nxt_an[idx] = 1'b0;
         nxt_seg     = lz_dark ? 7'h7F : decode(active_val[{idx, 2'b00} +: 4]);
         nxt_dp      = ~active_dp[idx];
      end
   end

   // Scan FSM, double buffer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         shadow_val <= '0;
         shadow_dp  <= '0;
         active_val <= '0;
         active_dp  <= '0;
         pending    <= 1'b0;
         load_ack   <= 1'b0;
         frame_tick <= 1'b0;
         seg_n      <= 7'h7F;
         dp_n       <= 1'b1;
         an_n       <= '1;
      end else begin
         // NOTE: non-blocking assignments here, so every right-hand side
         // reads the pre-edge value regardless of statement order.
         load_ack   <= 1'b0;
         frame_tick <= 1'b0;
         seg_n      <= nxt_seg;
         dp_n       <= nxt_dp;
         an_n       <= nxt_an;

         if (commit) begin
            active_val <= shadow_val;
            active_dp  <= shadow_dp;
            load_ack   <= 1'b1;
         end

         // A load in the commit cycle refills the shadow and keeps pending set.
         if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp_in;
            pending    <= 1'b1;
         end else if (commit) begin
            pending    <= 1'b0;
         end

         if (!enable) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state <= DRIVE;
                  idx   <= '0;
                  cnt   <= '0;
               end
               DRIVE: begin
                  if (cnt == DRIVE_LAST && BLANK_CYC == 0) cnt <= '0;
                  else if (cnt == DRIVE_LAST) begin
                     state <= BLANK;
                     cnt   <= cnt + 1'b1;
                  end else cnt <= cnt + 1'b1;
               end
               BLANK: begin
                  if (cnt == SLOT_LAST) begin
                     state <= DRIVE;
                     cnt   <= '0;
                  end else cnt <= cnt + 1'b1;
               end
               default: state <= IDLE;
            endcase

            if (slot_end) begin
               if (idx == IDX_LAST) begin
                  idx        <= '0;
                  frame_tick <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
         end
      end
   end

endmodule
